// File: rtl/ov7670_stream_tx.sv
// ov7670_stream_tx
// ----------------
// Transmitter for the OV7670 parallel pixel interface. It produces VGA-style
// frame and line timing on o_vsync/o_href and streams a deterministic RGB565
// test pattern, two bytes per pixel, on o_data.
//
// Optional feature macro: OV7670_TX_GRID_EN
//   defined   : pixel color comes from a 3x3 grid of 3-bit codes taken from
//               i_grid_colors, latched when VSYNC is entered
//   undefined : eight vertical color bars; i_grid_colors is ignored
//
// Ports
//   i_clk          pixel/byte clock, outputs change on its rising edge
//   i_rstn         asynchronous active-low reset
//   i_enable       start and keep producing frames
//   i_grid_colors  nine 3-bit region codes, region 0 in [26:24]
//   o_vsync        frame sync, active high
//   o_href         byte valid within an active line
//   o_data         RGB565 byte (even byte {R,G[5:3]}, odd byte {G[2:0],B})
//   o_sof          one-cycle pulse on the first vsync-high cycle
//   o_busy         high whenever not idle
//   o_frame_cnt    completed frames, wraps
module ov7670_stream_tx #(
  parameter int unsigned ACTIVE_W    = 640,
  parameter int unsigned ACTIVE_H    = 480,
  parameter int unsigned HBLANK      = 288,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned VBP_LINES   = 17,
  parameter int unsigned VFP_LINES   = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic [26:0] i_grid_colors,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned LINE_LEN     = 2 * ACTIVE_W + HBLANK;
  localparam int unsigned ACTIVE_BYTES = 2 * ACTIVE_W;
  localparam int unsigned MAX_A        = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int unsigned MAX_B        = (ACTIVE_H > VFP_LINES) ? ACTIVE_H : VFP_LINES;
  localparam int unsigned MAX_LINES    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned BW           = $clog2(LINE_LEN + 1);
  localparam int unsigned LW           = $clog2(MAX_LINES + 1);

  localparam logic [BW-1:0] LAST_BYTE  = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0] HREF_BYTES = BW'(ACTIVE_BYTES);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] byteCnt_q, byteCnt_d;
  logic [LW-1:0] lineCnt_q, lineCnt_d;
  logic [LW-1:0] lastLine;
  logic [15:0]   frameCnt_d;
  logic          sof_d;
  logic          latchGrid_d;
  logic          vsync_d;
  logic          href_d;
  logic          busy_d;
  logic [7:0]    data_d;
  logic [BW-1:0] xPix;
  logic [2:0]    code;
  logic [15:0]   pixel;

  function automatic logic [15:0] paletteRgb565(input logic [2:0] c);
    logic [15:0] rgb;
    case (c)
      3'd0:    rgb = 16'h0000;
      3'd1:    rgb = 16'hF800;
      3'd2:    rgb = 16'hFC00;
      3'd3:    rgb = 16'hFFE0;
      3'd4:    rgb = 16'h07E0;
      3'd5:    rgb = 16'h001F;
      3'd6:    rgb = 16'hFFFF;
      default: rgb = 16'hF81F;
    endcase
    return rgb;
  endfunction

  // Number of the final line period of the current blanking/active phase.
  always_comb begin
    case (state_q)
      VSYNC:   lastLine = LW'(VSYNC_LINES - 1);
      VBP:     lastLine = LW'(VBP_LINES - 1);
      ACTIVE:  lastLine = LW'(ACTIVE_H - 1);
      default: lastLine = LW'(VFP_LINES - 1);
    endcase
  end

  // Next-state logic. Every non-idle phase is a whole number of line periods,
  // so all phases share one byte/line counter pair that restarts per phase.
  always_comb begin
    state_d     = state_q;
    byteCnt_d   = byteCnt_q;
    lineCnt_d   = lineCnt_q;
    frameCnt_d  = o_frame_cnt;
    sof_d       = 1'b0;
    latchGrid_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_enable) begin
        state_d     = VSYNC;
        byteCnt_d   = '0;
        lineCnt_d   = '0;
        sof_d       = 1'b1;
        latchGrid_d = 1'b1;
      end
    end else if (byteCnt_q != LAST_BYTE) begin
      byteCnt_d = byteCnt_q + 1'b1;
    end else begin
      byteCnt_d = '0;
      if (lineCnt_q != lastLine) begin
        lineCnt_d = lineCnt_q + 1'b1;
      end else begin
        lineCnt_d = '0;
        case (state_q)
          VSYNC:  state_d = VBP;
          VBP:    state_d = ACTIVE;
          ACTIVE: state_d = VFP;
          default: begin
            // End of frame: count it and, if still enabled, start the next
            // frame with no gap cycle.
            frameCnt_d = o_frame_cnt + 16'd1;
            if (i_enable) begin
              state_d     = VSYNC;
              sof_d       = 1'b1;
              latchGrid_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  // Pattern generation, evaluated on the next-cycle counters so the outputs
  // can be registered and still line up with o_href.
  assign xPix = byteCnt_d >> 1;

`ifdef OV7670_TX_GRID_EN
  localparam logic [BW-1:0] COL_T1 = BW'(ACTIVE_W / 3);
  localparam logic [BW-1:0] COL_T2 = BW'(2 * (ACTIVE_W / 3));
  localparam logic [LW-1:0] ROW_T1 = LW'(ACTIVE_H / 3);
  localparam logic [LW-1:0] ROW_T2 = LW'(2 * (ACTIVE_H / 3));

  logic [26:0] gridColors_q;
  logic [1:0]  colIdx;
  logic [1:0]  rowIdx;
  logic [3:0]  region;

  always_comb begin
    colIdx = (xPix < COL_T1) ? 2'd0 : (xPix < COL_T2) ? 2'd1 : 2'd2;
    rowIdx = (lineCnt_d < ROW_T1) ? 2'd0 : (lineCnt_d < ROW_T2) ? 2'd1 : 2'd2;
    region = {2'b00, rowIdx} * 4'd3 + {2'b00, colIdx};
    case (region)
      4'd0:    code = gridColors_q[26:24];
      4'd1:    code = gridColors_q[23:21];
      4'd2:    code = gridColors_q[20:18];
      4'd3:    code = gridColors_q[17:15];
      4'd4:    code = gridColors_q[14:12];
      4'd5:    code = gridColors_q[11:9];
      4'd6:    code = gridColors_q[8:6];
      4'd7:    code = gridColors_q[5:3];
      4'd8:    code = gridColors_q[2:0];
      default: code = 3'd0;
    endcase
  end

  // Grid codes are frozen for the whole frame once VSYNC is entered.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gridColors_q <= '0;
    end else if (latchGrid_d) begin
      gridColors_q <= i_grid_colors;
    end
  end
`else
  localparam int unsigned BAR_W     = ACTIVE_W / 8;
  localparam logic [23:0] BAR_CODES = {3'd6, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1, 3'd2, 3'd0};

  logic unusedGrid;
  assign unusedGrid = ^{i_grid_colors, latchGrid_d};

  // Bar index is found by threshold comparison; columns past the eighth bar
  // (the division remainder) are black.
  always_comb begin
    code = BAR_CODES[23:21];
    for (int k = 1; k < 8; k++) begin
      if (xPix >= BW'(k * BAR_W)) code = BAR_CODES[23 - 3 * k -: 3];
    end
    if (xPix >= BW'(8 * BAR_W)) code = 3'd0;
  end
`endif

  assign pixel   = paletteRgb565(code);
  assign vsync_d = (state_d == VSYNC);
  assign busy_d  = (state_d != IDLE);
  assign href_d  = (state_d == ACTIVE) && (byteCnt_d < HREF_BYTES);
  assign data_d  = !href_d ? 8'h00 : (byteCnt_d[0] ? pixel[7:0] : pixel[15:8]);

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      byteCnt_q   <= '0;
      lineCnt_q   <= '0;
      o_vsync     <= 1'b0;
      o_href      <= 1'b0;
      o_data      <= 8'h00;
      o_sof       <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_cnt <= 16'h0000;
    end else begin
      state_q     <= state_d;
      byteCnt_q   <= byteCnt_d;
      lineCnt_q   <= lineCnt_d;
      o_vsync     <= vsync_d;
      o_href      <= href_d;
      o_data      <= data_d;
      o_sof       <= sof_d;
      o_busy      <= busy_d;
      o_frame_cnt <= frameCnt_d;
    end
  end

endmodule
